fifo_rd_stream: RTL
===================

FIFO_RD_STREAM -- requirements
Module: fifo_rd_stream

Interface
REQ-001 SHALL have parameter DWID, default 32, FIFO data width.
REQ-002 SHALL have parameter AWID, default 10, FIFO level width.
REQ-003 SHALL have parameter BLEN, default 16, maximum words per packet (2..1023).
REQ-004 SHALL have parameter TMO, default 255, number of idle cycles before a short packet is flushed (1..65535).
REQ-005 SHALL use one clock and an asynchronous, active-low reset: CLK input 1 system clock; RSTN input 1 async active-low reset.
REQ-006 FFRDENA  output  1  FIFO read enable.
REQ-007 FFRDDAT  input  DWID  FIFO read data, valid exactly 1 cycle after FFRDENA.
REQ-008 FFRDLEV  input  AWID  FIFO fill level, reflects reads issued up to the previous cycle.
REQ-009 M_VALID  output  1  stream word valid.
REQ-010 M_READY  input  1  stream sink ready.
REQ-011 M_DATA  output  DWID  stream data.
REQ-012 M_LAST  output  1  last word of packet.
REQ-013 PKTCNT  output  16  completed packets, wraps at 65535.
REQ-014 ERR  output  1  sticky sequence error (see Configuration).

Function
REQ-015 SHALL contain a 2-entry output buffer; a beat transfers when M_VALID && M_READY, and M_DATA/M_LAST SHALL hold stable while M_VALID && !M_READY.
REQ-016 SHALL track inflight reads (0..2); FFRDENA SHALL be 1 only when state=RUN, words issued < plen, buffer occupancy + inflight < 2, and FFRDLEV > inflight.
REQ-017 Each FFRDDAT word SHALL enter the buffer the cycle after its FFRDENA; the buffer SHALL never overflow or drop a word.
REQ-018 FSM states: IDLE, RUN, DRAIN.
REQ-019 IDLE: idle timer increments each cycle FFRDLEV != 0 and clears when FFRDLEV = 0; go to RUN with plen=BLEN when FFRDLEV >= BLEN, else with plen=FFRDLEV when timer reaches TMO; timer clears on exit.
REQ-020 RUN: go to DRAIN the cycle after the plen-th FFRDENA issues.
REQ-021 DRAIN: go to IDLE the cycle the word flagged M_LAST transfers; PKTCNT SHALL increment in that same cycle.
REQ-022 M_LAST SHALL be 1 exactly on the plen-th word of each packet.
REQ-023 Latency: with M_READY=1 and FFRDLEV >= BLEN, first M_VALID SHALL assert 3 cycles after entering IDLE-with-level (1 cycle to RUN, 1 to read, 1 data to buffer); sustained throughput 1 word/cycle.
REQ-024 FFRDLEV falling to 0 mid-packet SHALL stall reads without aborting; the packet resumes when data reappears.
REQ-025 Simultaneous buffer write and transfer in one cycle SHALL keep occupancy unchanged.

Reset
REQ-026 On RSTN low: FFRDENA, M_VALID, M_LAST, M_DATA, ERR = 0, PKTCNT = 0, state IDLE, buffer, inflight, timer and word counters cleared.
REQ-027 Reset mid-packet SHALL abandon the packet without an M_LAST; FIFO words read before reset are discarded.
REQ-028 Reset release SHALL be synchronised internally so that deassertion takes effect on the second CLK edge after RSTN rises.

Configuration
REQ-029 Macro FIFO_RD_SEQCHK_EN defined: on each transferred beat after the first since reset, ERR SHALL set (sticky until reset) if M_DATA != previous transferred M_DATA + 1 (mod 2^DWID).
REQ-030 Macro FIFO_RD_SEQCHK_EN undefined: no checker logic is built, and ERR SHALL be tied 0.

Verification
REQ-031 FFRDLEV=40 (model FIFO holding 0..39), M_READY=1 -> two 16-word packets of data 0..31, M_LAST on 15 and 31, PKTCNT=2, then 8 words flushed TMO cycles later with M_LAST on 39, PKTCNT=3.
REQ-032 5 words written, no more -> no M_VALID for TMO cycles, then one 5-word packet, M_LAST on word 5.
REQ-033 M_READY toggled randomly 50% during a 16-word burst -> all words delivered in order, none duplicated; FFRDENA never issued with occupancy+inflight = 2.
REQ-034 RSTN pulled low on word 7 of a packet -> all outputs 0 within the same cycle; after release, the next packet starts with a fresh word count and PKTCNT=0.
REQ-035 FIFO_RD_SEQCHK_EN defined, data 0,1,2,4 -> ERR=1 the cycle after 4 transfers and stays 1; macro undefined, same stimulus -> ERR=0.

Source files
------------

// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream
// Pulls words out of a 1-cycle-latency FIFO and emits them as a valid/ready
// stream cut into packets. A packet is BLEN words when the FIFO holds at least
// BLEN, otherwise whatever is present after TMO idle cycles is flushed as a
// short packet. The last word of each packet carries M_LAST.
//
// Optional build macro: FIFO_RD_SEQCHK_EN -- when defined, ERR latches if two
// consecutive transferred words are not incrementing by one; when undefined
// ERR is tied low and no checker is built.
//
// Ports
//   CLK, RSTN      clock, asynchronous active-low reset (release synchronised)
//   FFRDENA        FIFO read enable
//   FFRDDAT        FIFO read data, valid the cycle after FFRDENA
//   FFRDLEV        FIFO fill level (already net of reads up to last cycle)
//   M_VALID/M_READY/M_DATA/M_LAST  output stream
//   PKTCNT         completed packet counter (wraps)
//   ERR            sticky sequence error
module fifo_rd_stream #(
  parameter int DWID = 32,
  parameter int AWID = 10,
  parameter int BLEN = 16,
  parameter int TMO  = 255
) (
  input  logic            CLK,
  input  logic            RSTN,
  output logic            FFRDENA,
  input  logic [DWID-1:0] FFRDDAT,
  input  logic [AWID-1:0] FFRDLEV,
  output logic            M_VALID,
  input  logic            M_READY,
  output logic [DWID-1:0] M_DATA,
  output logic            M_LAST,
  output logic [15:0]     PKTCNT,
  output logic            ERR
);

  localparam int PLW = $clog2(BLEN + 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  // Assertion is immediate; release reaches the logic on the second edge.
  logic [1:0] r_rst_sync;
  logic       w_rstn;

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) r_rst_sync <= 2'b00;
    else       r_rst_sync <= {r_rst_sync[0], 1'b1};
  end

  assign w_rstn = r_rst_sync[1];

  state_t          r_state, w_state_nxt;
  logic [PLW-1:0]  r_plen, r_issued;
  logic [15:0]     r_timer;
  logic [15:0]     r_pktcnt;
  logic            r_vld_p1, r_last_p1;
  logic [DWID:0]   r_e0, r_e1;           // {last, data}; r_e0 is the head
  logic [1:0]      r_occ;
  logic [DWID:0]   w_e0_nxt, w_e1_nxt;
  logic [1:0]      w_occ_nxt;
  logic [1:0]      w_occ_eff;
  logic            w_xfer, w_rd_en, w_lev_full, w_tmo_hit, w_last_issue, w_last_xfer;

  assign M_VALID     = (r_occ != 2'd0);
  assign M_DATA      = r_e0[DWID-1:0];
  assign M_LAST      = r_e0[DWID];
  assign PKTCNT      = r_pktcnt;
  assign w_xfer      = M_VALID && M_READY;
  // Slot freed by this cycle's transfer counts as room, which keeps 1 word/cycle.
  assign w_occ_eff   = r_occ - {1'b0, w_xfer};
  assign w_lev_full  = 32'(FFRDLEV) >= 32'(BLEN);
  assign w_tmo_hit   = (FFRDLEV != '0) && (r_timer == 16'(TMO));

  assign w_rd_en = (r_state == S_RUN) && (r_issued < r_plen) &&
                   ((3'(w_occ_eff) + 3'(r_vld_p1)) < 3'd2) &&
                   (FFRDLEV > AWID'(r_vld_p1));
  assign FFRDENA = w_rd_en;

  assign w_last_issue = w_rd_en && ((r_issued + PLW'(1)) == r_plen);
  assign w_last_xfer  = w_xfer && M_LAST;

  always_ff @(posedge CLK or negedge w_rstn) begin
    if (!w_rstn) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_lev_full || w_tmo_hit) w_state_nxt = S_RUN;
      S_RUN:   if (w_last_issue)            w_state_nxt = S_DRAIN;
      S_DRAIN: if (w_last_xfer)             w_state_nxt = S_IDLE;
      default:                              w_state_nxt = S_IDLE;
    endcase
  end

  // Packet length capture, idle timer and issue counter
  always_ff @(posedge CLK or negedge w_rstn) begin
    if (!w_rstn) begin
      r_plen   <= '0;
      r_issued <= '0;
      r_timer  <= '0;
    end else if (r_state == S_IDLE) begin
      if (w_state_nxt == S_RUN) begin
        r_plen   <= w_lev_full ? PLW'(BLEN) : PLW'(FFRDLEV);
        r_issued <= '0;
        r_timer  <= '0;
      end else if (FFRDLEV != '0) begin
        r_timer  <= r_timer + 16'd1;
      end else begin
        r_timer  <= '0;
      end
    end else if (w_rd_en) begin
      r_issued <= r_issued + PLW'(1);
    end
  end

  // Stage p1: read issued last cycle, its data is on FFRDDAT now
  always_ff @(posedge CLK or negedge w_rstn) begin
    if (!w_rstn) begin
      r_vld_p1  <= 1'b0;
      r_last_p1 <= 1'b0;
    end else begin
      r_vld_p1  <= w_rd_en;
      r_last_p1 <= w_last_issue;
    end
  end

  // Two-entry buffer: pop from head on transfer, then append arriving word
  always_comb begin
    w_e0_nxt  = r_e0;
    w_e1_nxt  = r_e1;
    w_occ_nxt = r_occ;
    if (w_xfer) begin
      w_e0_nxt  = r_e1;
      w_occ_nxt = r_occ - 2'd1;
    end
    if (r_vld_p1) begin
      if (w_occ_nxt == 2'd0) w_e0_nxt = {r_last_p1, FFRDDAT};
      else                   w_e1_nxt = {r_last_p1, FFRDDAT};
      w_occ_nxt = w_occ_nxt + 2'd1;
    end
  end

  always_ff @(posedge CLK or negedge w_rstn) begin
    if (!w_rstn) begin
      r_e0     <= '0;
      r_e1     <= '0;
      r_occ    <= 2'd0;
      r_pktcnt <= 16'd0;
    end else begin
      r_e0  <= w_e0_nxt;
      r_e1  <= w_e1_nxt;
      r_occ <= w_occ_nxt;
      if (w_last_xfer) r_pktcnt <= r_pktcnt + 16'd1;
    end
  end

`ifdef FIFO_RD_SEQCHK_EN
  logic [DWID-1:0] r_prev;
  logic            r_seen;
  logic            r_err;

  always_ff @(posedge CLK or negedge w_rstn) begin
    if (!w_rstn) begin
      r_prev <= '0;
      r_seen <= 1'b0;
      r_err  <= 1'b0;
    end else if (w_xfer) begin
      if (r_seen && (M_DATA != (r_prev + DWID'(1)))) r_err <= 1'b1;
      r_prev <= M_DATA;
      r_seen <= 1'b1;
    end
  end

  assign ERR = r_err;
`else
  assign ERR = 1'b0;
`endif

endmodule
